// File: rtl/windowed_feature_extractor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// windowed_feature_extractor : sliding-window mean / variance / std engine
// Rev 1.0
// ---------------------------------------------------------------------------
module windowed_feature_extractor #(
  parameter int DATA_W   = 16,
  parameter int WIN_LOG2 = 7,
  parameter int HOP      = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_sclr,
  input  logic                i_data_valid,
  input  logic [DATA_W-1:0]   i_sample,
  output logic                o_feature_valid,
  output logic [DATA_W-1:0]   o_feature_mean,
  output logic [2*DATA_W-1:0] o_feature_var,
  output logic [DATA_W-1:0]   o_feature_std,
  output logic                o_window_ready,
  output logic                o_overrun
);

  localparam int c_W      = 1 << WIN_LOG2;
  localparam int c_FILL_W = WIN_LOG2 + 1;
  localparam int c_SUM_W  = DATA_W + WIN_LOG2;
  localparam int c_SQ_W   = 2*DATA_W + WIN_LOG2;
  localparam int c_VAR_W  = 2*DATA_W;
  localparam int c_HOP_W  = (HOP > 1) ? $clog2(HOP) : 1;
  localparam int c_CNT_W  = $clog2(DATA_W + 1);
  localparam int c_REM_W  = DATA_W + 4;

  localparam logic [c_FILL_W-1:0] c_FILL_FULL = {1'b1, {WIN_LOG2{1'b0}}};
  localparam logic [c_FILL_W-1:0] c_FILL_LAST = {1'b0, {WIN_LOG2{1'b1}}};
  localparam logic [c_HOP_W-1:0]  c_HOP_LAST  = c_HOP_W'(HOP - 1);
  localparam logic [c_CNT_W-1:0]  c_SQRT_LAST = c_CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SQRT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Sample path state
  logic [DATA_W-1:0]   r_buf [c_W];
  logic [WIN_LOG2-1:0] r_wr_ptr;
  logic [c_FILL_W-1:0] r_fill;
  logic [c_HOP_W-1:0]  r_hop;
  logic [c_SUM_W-1:0]  r_sum;
  logic [c_SQ_W-1:0]   r_sumsq;
  logic                r_window_ready;

  // Feature FSM state
  state_t              r_state;
  logic [DATA_W-1:0]   r_mean;
  logic [c_VAR_W-1:0]  r_var;
  logic [c_VAR_W-1:0]  r_rad;
  logic [c_REM_W-1:0]  r_rem;
  logic [DATA_W-1:0]   r_root;
  logic [c_CNT_W-1:0]  r_cnt;
  logic                r_feature_valid;
  logic [DATA_W-1:0]   r_feature_mean;
  logic [c_VAR_W-1:0]  r_feature_var;
  logic [DATA_W-1:0]   r_feature_std;
  logic                r_overrun;

  logic                w_accept;
  logic                w_full;
  logic                w_fill_last;
  logic                w_trigger;
  logic [DATA_W-1:0]   w_old;
  logic [c_VAR_W-1:0]  w_new_sq;
  logic [c_VAR_W-1:0]  w_old_sq;
  logic [c_SUM_W-1:0]  w_new_ext;
  logic [c_SUM_W-1:0]  w_old_ext;
  logic [c_SQ_W-1:0]   w_new_sq_ext;
  logic [c_SQ_W-1:0]   w_old_sq_ext;
  logic [DATA_W-1:0]   w_mean;
  logic [c_VAR_W-1:0]  w_ms;
  logic [c_VAR_W-1:0]  w_mean_sq;
  logic [c_VAR_W-1:0]  w_var;
  logic                w_rem_neg;
  logic [c_REM_W-1:0]  w_rem_sh;
  logic [c_REM_W-1:0]  w_rem_nxt;
  logic [DATA_W-1:0]   w_root_nxt;

  assign w_accept    = i_data_valid & ~i_sclr;
  assign w_full      = (r_fill == c_FILL_FULL);
  assign w_fill_last = ~w_full & (r_fill == c_FILL_LAST);
  assign w_trigger   = w_accept & (w_fill_last | (w_full & (r_hop == c_HOP_LAST)));

  // Until the window has filled, the slot being overwritten holds no live sample
  assign w_old        = w_full ? r_buf[r_wr_ptr] : '0;
  assign w_new_sq     = {{DATA_W{1'b0}}, i_sample} * {{DATA_W{1'b0}}, i_sample};
  assign w_old_sq     = {{DATA_W{1'b0}}, w_old} * {{DATA_W{1'b0}}, w_old};
  assign w_new_ext    = {{WIN_LOG2{1'b0}}, i_sample};
  assign w_old_ext    = {{WIN_LOG2{1'b0}}, w_old};
  assign w_new_sq_ext = {{WIN_LOG2{1'b0}}, w_new_sq};
  assign w_old_sq_ext = {{WIN_LOG2{1'b0}}, w_old_sq};

  assign w_mean    = r_sum[c_SUM_W-1 -: DATA_W];
  assign w_ms      = r_sumsq[c_SQ_W-1 -: c_VAR_W];
  assign w_mean_sq = {{DATA_W{1'b0}}, w_mean} * {{DATA_W{1'b0}}, w_mean};
  assign w_var     = (w_ms >= w_mean_sq) ? (w_ms - w_mean_sq) : '0;

  // Non-restoring root step; the remainder is bounded so its top two bits both carry the sign
  assign w_rem_neg  = |r_rem[c_REM_W-1 -: 2];
  assign w_rem_sh   = {r_rem[c_REM_W-3:0], r_rad[c_VAR_W-1 -: 2]};
  assign w_rem_nxt  = w_rem_neg ? (w_rem_sh + {2'b00, r_root, 2'b11})
                                : (w_rem_sh - {2'b00, r_root, 2'b01});
  assign w_root_nxt = {r_root[DATA_W-2:0], ~w_rem_nxt[c_REM_W-1]};

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[r_wr_ptr] <= i_sample;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr       <= '0;
      r_fill         <= '0;
      r_hop          <= '0;
      r_sum          <= '0;
      r_sumsq        <= '0;
      r_window_ready <= 1'b0;
    end else if (i_sclr) begin
      r_wr_ptr       <= '0;
      r_fill         <= '0;
      r_hop          <= '0;
      r_sum          <= '0;
      r_sumsq        <= '0;
      r_window_ready <= 1'b0;
    end else if (i_data_valid) begin
      r_wr_ptr <= r_wr_ptr + WIN_LOG2'(1);
      r_sum    <= r_sum + w_new_ext - w_old_ext;
      r_sumsq  <= r_sumsq + w_new_sq_ext - w_old_sq_ext;
      if (!w_full) begin
        r_fill <= r_fill + c_FILL_W'(1);
      end
      if (w_fill_last) begin
        r_window_ready <= 1'b1;
      end
      if (w_trigger) begin
        r_hop <= '0;
      end else if (w_full) begin
        r_hop <= r_hop + c_HOP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_mean          <= '0;
      r_var           <= '0;
      r_rad           <= '0;
      r_rem           <= '0;
      r_root          <= '0;
      r_cnt           <= '0;
      r_feature_valid <= 1'b0;
      r_feature_mean  <= '0;
      r_feature_var   <= '0;
      r_feature_std   <= '0;
      r_overrun       <= 1'b0;
    end else begin
      r_feature_valid <= 1'b0;
      r_overrun       <= w_trigger & (r_state != S_IDLE);
      if (i_sclr) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_trigger) begin
              r_state <= S_CALC;
            end
          end
          S_CALC: begin
            r_mean  <= w_mean;
            r_var   <= w_var;
            r_rad   <= w_var;
            r_rem   <= '0;
            r_root  <= '0;
            r_cnt   <= c_SQRT_LAST;
            r_state <= S_SQRT;
          end
          S_SQRT: begin
            r_rad  <= {r_rad[c_VAR_W-3:0], 2'b00};
            r_rem  <= w_rem_nxt;
            r_root <= w_root_nxt;
            if (r_cnt == '0) begin
              r_state <= S_DONE;
            end else begin
              r_cnt <= r_cnt - c_CNT_W'(1);
            end
          end
          S_DONE: begin
            r_feature_mean  <= r_mean;
            r_feature_var   <= r_var;
            r_feature_std   <= r_root;
            r_feature_valid <= 1'b1;
            r_state         <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_feature_valid = r_feature_valid;
  assign o_feature_mean  = r_feature_mean;
  assign o_feature_var   = r_feature_var;
  assign o_feature_std   = r_feature_std;
  assign o_window_ready  = r_window_ready;
  assign o_overrun       = r_overrun;

endmodule
`default_nettype wire

// File: doc/windowed_feature_extractor.md
# windowed_feature_extractor

Parametrised sliding-window statistics engine for the fall-detection feature path. It accepts a stream of unsigned acceleration-magnitude samples and keeps a circular buffer of the last 2^WIN_LOG2 samples, with running sum and sum-of-squares. Every HOP accepted samples it publishes mean, variance and standard deviation of the current window. It sits between the magnitude stage and the classifier, and replaces the fixed 100-sample, non-overlapping extractor with power-of-two windows, overlap and overrun reporting.

## Interface
- DATA_W, 16, sample width; also width of mean and std
- WIN_LOG2, 7, window length W = 2^WIN_LOG2 samples
- HOP, 32, samples between successive feature outputs; legal range 1..W
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- sclr  in  1  synchronous clear: empties window, aborts computation
- data_valid  in  1  sample qualifier; every asserted cycle accepts one sample
- sample  in  DATA_W  unsigned magnitude
- feature_valid  out  1  one-cycle pulse, features valid
- feature_mean  out  DATA_W  window mean
- feature_var  out  2*DATA_W  window variance
- feature_std  out  DATA_W  floor(sqrt(feature_var))
- window_ready  out  1  high once W samples are held since reset/sclr
- overrun  out  1  one-cycle pulse, a window trigger was dropped

## Operation
- Reset values: all outputs 0, buffer pointer 0, fill count 0, hop count 0, sums 0, FSM IDLE. Buffer RAM contents need not be reset.
- Sample path runs independently of the FSM. It never stalls, so there is no ready output.
- On each accepted sample:
  - write it at wr_ptr; wr_ptr wraps W-1 -> 0.
  - sum += new - old; sumsq += new^2 - old^2. old is the entry being overwritten, treated as 0 while fill count < W.
- Widths:
  - sum is DATA_W+WIN_LOG2 bits; sumsq is 2*DATA_W+WIN_LOG2 bits.
  - No overflow is possible. Arithmetic is exact and unsigned.
- Trigger: the accepted sample that brings fill count to W, then every HOP-th accepted sample after that (hop counter clears on each trigger).
- FSM states:
  - IDLE: on trigger -> CALC.
  - CALC: mean = sum >> WIN_LOG2 (truncating); ms = sumsq >> WIN_LOG2; var = ms - mean^2, clamped to 0 if negative; -> SQRT.
  - SQRT: non-restoring integer square root of var, one result bit per cycle, exactly DATA_W cycles; -> DONE.
  - DONE: register mean/var/std onto outputs, pulse feature_valid; -> IDLE.
- Trigger while FSM is not IDLE: the window is dropped and overrun pulses on the next cycle. Sums and counters keep updating. The computation in flight completes unaffected.
- feature_mean/var/std hold their last values until the next DONE.
- sclr: in the next cycle, fill count, hop count, sums and wr_ptr go to 0, window_ready goes to 0, FSM goes to IDLE, and no feature_valid is issued for the aborted computation. Output feature registers are not cleared. A sample presented together with sclr is discarded.

## Timing
- Trigger sample accepted at edge E0: the sums include it after E0; CALC is the cycle after E0.
- feature_valid is high for exactly one cycle, starting at edge E0 + DATA_W + 2. Default latency is 18 cycles.
- Minimum HOP for continuous data_valid without overrun is DATA_W + 3 cycles.
- window_ready rises at the edge that accepts the W-th sample.
- reset_n deasserting mid-operation: everything returns immediately to reset values, and the next window needs W new samples.

## Test plan
- 128 samples of 1000, defaults (W=128, HOP=32):
  - feature_valid 18 cycles after the 128th sample: mean 1000, var 0, std 0.
  - then every 32 samples with identical values.
- Alternating 0/200 over 128 samples -> mean 100, var 10000, std 100.
- 128 samples of 65535 -> mean 65535, var 0, std 0; no wrap in sum/sumsq.
- 128 samples of 0, then 32 samples of 640:
  - second output: mean 160, var 76800, std 277.
  - checks that old samples are subtracted correctly.
- HOP=4 with continuous valid:
  - overrun pulses at the 2nd..5th triggers (within 19 cycles of first), dropped windows produce no feature_valid.
  - the next accepted trigger yields correct statistics.
- sclr asserted in the SQRT state:
  - no feature_valid, window_ready drops.
  - the next output comes only after 128 further samples.
- Repeat the test with reset_n pulsed low mid-fill.
